// File: rtl/bus_master_port.sv
// bus_master_port
//   Master-side port of the shared serial bus. Latches one read or write
//   request from the application, requests the bus, shifts slave id,
//   address and (for writes) data out LSB first, collects read data, and
//   pulses m_tx_done when the transfer finishes.
//
//   Optional feature: define MASTER_TIMEOUT_EN to bound the ready and
//   read-data waits to TIMEOUT_CYCLES cycles. A timeout ends the transfer
//   with m_error and m_tx_done pulsed together. Without the macro the
//   waits are unbounded and m_error stays 0.
//
// Ports
//   clk, reset       clock (rising edge), async active-low reset
//   m_instruction    00 idle, 01 read, 10 write, 11 ignored
//   m_data_in        write data
//   m_address        target address
//   m_slave_id       target slave
//   m_tx_done        one-cycle completion pulse
//   m_rx_data        last completed read word
//   m_busy           request accepted, up to and including m_tx_done
//   m_error          timeout abort, pulses with m_tx_done
//   bus_req/grant    arbitration handshake
//   bus_mode         1 write, 0 read (valid with bus_req)
//   bus_out(_valid)  serial data towards slave
//   bus_ready        slave ready
//   bus_in(_valid)   serial read data from slave
//
// state       | meaning
// ------------+---------------------------------------------------
// S_IDLE      | waiting for an armed read/write instruction
// S_REQ       | request latched, bus_req high, waiting for grant
// S_SEND_ID   | shifting slave id out
// S_SEND_ADDR | shifting address out
// S_WAIT_RDY  | waiting for bus_ready from the slave
// S_SEND_DATA | shifting write data out
// S_RX_DATA   | collecting read data bits
// S_DONE      | m_tx_done pulse, bus released

module bus_master_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int SLAVE_ID_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                m_instruction,
  input  logic [DATA_WIDTH-1:0]     m_data_in,
  input  logic [ADDR_WIDTH-1:0]     m_address,
  input  logic [SLAVE_ID_WIDTH-1:0] m_slave_id,
  output logic                      m_tx_done,
  output logic [DATA_WIDTH-1:0]     m_rx_data,
  output logic                      m_busy,
  output logic                      m_error,
  output logic                      bus_req,
  input  logic                      bus_grant,
  output logic                      bus_mode,
  output logic                      bus_out,
  output logic                      bus_out_valid,
  input  logic                      bus_ready,
  input  logic                      bus_in,
  input  logic                      bus_in_valid
);

  localparam int SHW_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int SHW    = (SHW_AD > SLAVE_ID_WIDTH) ? SHW_AD : SLAVE_ID_WIDTH;
  localparam int CW     = (SHW > 1) ? $clog2(SHW) : 1;

  localparam logic [CW-1:0] ID_LAST   = CW'(SLAVE_ID_WIDTH - 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SEND_ID,
    S_SEND_ADDR,
    S_WAIT_RDY,
    S_SEND_DATA,
    S_RX_DATA,
    S_DONE
  } state_t;

  state_t                    state;
  logic                      armed;
  logic                      lat_write;
  logic [SLAVE_ID_WIDTH-1:0] lat_id;
  logic [ADDR_WIDTH-1:0]     lat_addr;
  logic [DATA_WIDTH-1:0]     lat_data;
  logic [SHW-1:0]            tx_shift;
  logic [DATA_WIDTH-1:0]     rx_shift;
  logic [DATA_WIDTH-1:0]     rx_next;
  logic [CW-1:0]             bit_cnt;
  logic                      grant_lost;
  logic                      timeout_fire;

  assign rx_next    = {bus_in, rx_shift[DATA_WIDTH-1:1]};
  assign grant_lost = !bus_grant &&
                      (state inside {S_SEND_ID, S_SEND_ADDR, S_WAIT_RDY,
                                     S_SEND_DATA, S_RX_DATA});

`ifdef MASTER_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          waiting;
  logic          progress;

  assign waiting  = (state == S_WAIT_RDY) || (state == S_RX_DATA);
  assign progress = bus_ready || bus_in_valid;
  // Fires in the last of TIMEOUT_CYCLES idle wait cycles, so DONE lands
  // exactly TIMEOUT_CYCLES cycles after the wait began.
  assign timeout_fire = waiting && bus_grant && !progress && (to_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= TO_LOAD;
    end else if (!waiting || progress) begin
      to_cnt <= TO_LOAD;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - TW'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Outputs are registered and set on the transition into the state that
  // owns them, so bus_out carries field bit 0 in the first cycle of a field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      armed         <= 1'b1;
      lat_write     <= 1'b0;
      lat_id        <= '0;
      lat_addr      <= '0;
      lat_data      <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      m_tx_done     <= 1'b0;
      m_rx_data     <= '0;
      m_busy        <= 1'b0;
      m_error       <= 1'b0;
      bus_req       <= 1'b0;
      bus_mode      <= 1'b0;
      bus_out       <= 1'b0;
      bus_out_valid <= 1'b0;
    end else if (grant_lost) begin
      // Lost the bus: keep the latched request and start over from the id.
      state         <= S_REQ;
      bit_cnt       <= '0;
      bus_out       <= 1'b0;
      bus_out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (armed && (m_instruction == 2'b01 || m_instruction == 2'b10)) begin
            lat_write <= m_instruction[1];
            lat_id    <= m_slave_id;
            lat_addr  <= m_address;
            lat_data  <= m_data_in;
            armed     <= 1'b0;
            state     <= S_REQ;
            bus_req   <= 1'b1;
            bus_mode  <= m_instruction[1];
            m_busy    <= 1'b1;
          end else if (m_instruction == 2'b00) begin
            armed <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus_grant) begin
            state         <= S_SEND_ID;
            bit_cnt       <= '0;
            bus_out       <= lat_id[0];
            tx_shift      <= SHW'(lat_id) >> 1;
            bus_out_valid <= 1'b1;
            rx_shift      <= '0;
          end
        end

        S_SEND_ID: begin
          if (bit_cnt == ID_LAST) begin
            state    <= S_SEND_ADDR;
            bit_cnt  <= '0;
            bus_out  <= lat_addr[0];
            tx_shift <= SHW'(lat_addr) >> 1;
          end else begin
            bit_cnt  <= bit_cnt + CW'(1);
            bus_out  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end

        S_SEND_ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            state         <= S_WAIT_RDY;
            bit_cnt       <= '0;
            bus_out       <= 1'b0;
            bus_out_valid <= 1'b0;
          end else begin
            bit_cnt  <= bit_cnt + CW'(1);
            bus_out  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end

        S_WAIT_RDY: begin
          if (timeout_fire) begin
            state     <= S_DONE;
            m_tx_done <= 1'b1;
            m_error   <= 1'b1;
            bus_req   <= 1'b0;
          end else if (bus_ready) begin
            bit_cnt <= '0;
            if (lat_write) begin
              state         <= S_SEND_DATA;
              bus_out       <= lat_data[0];
              tx_shift      <= SHW'(lat_data) >> 1;
              bus_out_valid <= 1'b1;
            end else begin
              state    <= S_RX_DATA;
              rx_shift <= '0;
            end
          end
        end

        S_SEND_DATA: begin
          if (bit_cnt == DATA_LAST) begin
            state         <= S_DONE;
            bit_cnt       <= '0;
            bus_out       <= 1'b0;
            bus_out_valid <= 1'b0;
            m_tx_done     <= 1'b1;
            bus_req       <= 1'b0;
          end else begin
            bit_cnt  <= bit_cnt + CW'(1);
            bus_out  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end

        S_RX_DATA: begin
          if (timeout_fire) begin
            state     <= S_DONE;
            m_tx_done <= 1'b1;
            m_error   <= 1'b1;
            bus_req   <= 1'b0;
          end else if (bus_in_valid) begin
            rx_shift <= rx_next;
            if (bit_cnt == DATA_LAST) begin
              state     <= S_DONE;
              bit_cnt   <= '0;
              m_rx_data <= rx_next;
              m_tx_done <= 1'b1;
              bus_req   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          m_tx_done <= 1'b0;
          m_error   <= 1'b0;
          m_busy    <= 1'b0;
          bus_mode  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
